// File: rtl/escaneo_pkg.sv
// Shared constants and Gray/binary helpers for the seven-segment scan driver.
//   SLOT_UNI / SLOT_DEC : digit slots carrying units and tens
//   ANODO_*             : active-low anode patterns
//   gray_a_bin          : 4-bit Gray -> binary
//   bin_a_gray          : 4-bit binary -> Gray
package escaneo_pkg;

   localparam logic [1:0] SLOT_UNI = 2'd0;
   localparam logic [1:0] SLOT_DEC = 2'd1;

   localparam logic [3:0] ANODO_APAGADO = 4'b1111;
   localparam logic [3:0] ANODO_UNI     = 4'b1110;
   localparam logic [3:0] ANODO_DEC     = 4'b1101;

   function automatic logic [3:0] gray_a_bin(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [3:0] bin_a_gray(input logic [3:0] d);
      return d ^ (d >> 1);
   endfunction

endpackage

// File: rtl/escaneo_display_gray_a_binario.sv
// Combinational 4-bit Gray-to-binary converter.
//   i_gray : Gray-coded input
//   o_bin  : binary equivalent
module gray_a_binario
   import escaneo_pkg::*;
(
   input  logic [3:0] i_gray,
   output logic [3:0] o_bin
);

   assign o_bin = gray_a_bin(i_gray);

endmodule

// File: rtl/escaneo_display.sv
// Time-multiplexed four-digit seven-segment scan driver. A Gray-coded value
// is captured into a pending register and promoted to the shown register only
// at frame wrap, so a frame never mixes digits of two values. Units are shown
// on slot 0, tens on slot 1; slots 2 and 3 stay dark.
// Build option: BLANK_LEADING_ZERO_EN darkens the tens digit for values < 10.
//   clk            : system clock
//   rst            : synchronous active-high reset
//   carga          : load strobe for gray_in
//   gray_in        : Gray-coded value 0..15
//   refrescamiento : current digit slot (registered)
//   digito         : Gray-coded digit for the slot (registered)
//   anodo          : one-hot active-low anode enables (registered)
module escaneo_display
   import escaneo_pkg::*;
#(
   parameter int DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       carga,
   input  logic [3:0] gray_in,
   output logic [1:0] refrescamiento,
   output logic [3:0] digito,
   output logic [3:0] anodo
);

   localparam int             CW      = $clog2(DIV);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_sel;
   logic [3:0]    r_pend;
   logic [3:0]    r_vis;
   logic [1:0]    r_refresco;
   logic [3:0]    r_digito;
   logic [3:0]    r_anodo;

   logic          w_tick;
   logic [3:0]    w_bin;
   logic          w_dec;
   logic [3:0]    w_uni;
   logic [3:0]    w_dece;

   assign w_tick = (r_cnt == CNT_MAX);

   gray_a_binario u_conv (
      .i_gray (r_vis),
      .o_bin  (w_bin)
   );

   assign w_dec  = (w_bin >= 4'd10);
   assign w_uni  = w_dec ? (w_bin - 4'd10) : w_bin;
   assign w_dece = {3'b000, w_dec};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_sel      <= 2'd0;
         r_pend     <= 4'd0;
         r_vis      <= 4'd0;
         r_refresco <= 2'd0;
         r_digito   <= 4'd0;
         r_anodo    <= ANODO_APAGADO;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
         if (w_tick) begin
            r_sel <= r_sel + 2'd1;
         end
         if (carga) begin
            r_pend <= gray_in;
         end
         // Frame wrap: promote the pending value as it stood before this edge.
         if (w_tick && (r_sel == 2'd3)) begin
            r_vis <= r_pend;
         end

         r_refresco <= r_sel;
         case (r_sel)
            SLOT_UNI: begin
               r_anodo  <= ANODO_UNI;
               r_digito <= bin_a_gray(w_uni);
            end
            SLOT_DEC: begin
`ifdef BLANK_LEADING_ZERO_EN
               if (w_dec) begin
                  r_anodo  <= ANODO_DEC;
                  r_digito <= bin_a_gray(w_dece);
               end else begin
                  r_anodo  <= ANODO_APAGADO;
                  r_digito <= 4'd0;
               end
`else
               r_anodo  <= ANODO_DEC;
               r_digito <= bin_a_gray(w_dece);
`endif
            end
            default: begin
               r_anodo  <= ANODO_APAGADO;
               r_digito <= 4'd0;
            end
         endcase
      end
   end

   assign refrescamiento = r_refresco;
   assign digito         = r_digito;
   assign anodo          = r_anodo;

endmodule

// File: tb/tb_escaneo_display.sv
// Bench for escaneo_display with DIV=4. A behavioural model predicts each
// cycle's outputs into a queue; the queue is drained and compared half a cycle
// later. Directed checks against fixed values cover the key scenarios.
module tb_escaneo_display;

   localparam int DIV = 4;

   logic       clk;
   logic       rst;
   logic       carga;
   logic [3:0] gray_in;
   logic [1:0] refrescamiento;
   logic [3:0] digito;
   logic [3:0] anodo;

   escaneo_display #(.DIV(DIV)) dut (
      .clk            (clk),
      .rst            (rst),
      .carga          (carga),
      .gray_in        (gray_in),
      .refrescamiento (refrescamiento),
      .digito         (digito),
      .anodo          (anodo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] r;
      logic [3:0] d;
      logic [3:0] a;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   int         m_cnt;
   logic [1:0] m_sel;
   logic [3:0] m_pend;
   logic [3:0] m_vis;
   logic [1:0] m_ref;
   logic [3:0] m_dig;
   logic [3:0] m_ano;

   function automatic logic [3:0] to_gray(input logic [3:0] d);
      return d ^ (d >> 1);
   endfunction

   task automatic model_edge();
      logic [3:0] val;
      int         tens;
      int         units;
      bit         tick;
      if (rst) begin
         m_cnt = 0; m_sel = 2'd0; m_pend = 4'd0; m_vis = 4'd0;
         m_ref = 2'd0; m_dig = 4'd0; m_ano = 4'b1111;
      end else begin
         val   = m_vis ^ (m_vis >> 1) ^ (m_vis >> 2) ^ (m_vis >> 3);
         tens  = int'(val) / 10;
         units = int'(val) % 10;
         m_ref = m_sel;
         case (m_sel)
            2'd0: begin m_ano = 4'b1110; m_dig = to_gray(4'(units)); end
            2'd1: begin
`ifdef BLANK_LEADING_ZERO_EN
               if (tens == 0) begin m_ano = 4'b1111; m_dig = 4'd0; end
               else begin m_ano = 4'b1101; m_dig = to_gray(4'(tens)); end
`else
               m_ano = 4'b1101; m_dig = to_gray(4'(tens));
`endif
            end
            default: begin m_ano = 4'b1111; m_dig = 4'd0; end
         endcase
         tick = (m_cnt == DIV - 1);
         if (tick && m_sel == 2'd3) m_vis = m_pend;
         if (carga) m_pend = gray_in;
         m_cnt = tick ? 0 : m_cnt + 1;
         if (tick) m_sel = m_sel + 2'd1;
      end
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      model_edge();
      e.r = m_ref; e.d = m_dig; e.a = m_ano;
      q.push_back(e);
      @(negedge clk);
      n_cmp++;
      assert (q.size() > 0) else begin
         n_err++;
         $error("FAIL sb_empty: queue size %0d required >0", q.size());
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         n_cmp++;
         assert (refrescamiento === e.r) else begin
            n_err++;
            $error("FAIL sb_ref: got %b expected %b", refrescamiento, e.r);
         end
         n_cmp++;
         assert (digito === e.d) else begin
            n_err++;
            $error("FAIL sb_digito: got %b expected %b", digito, e.d);
         end
         n_cmp++;
         assert (anodo === e.a) else begin
            n_err++;
            $error("FAIL sb_anodo: got %b expected %b", anodo, e.a);
         end
      end
   endtask

   task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic go_slot(input logic [1:0] s);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 10 * DIV && !hit; i++) begin
         step();
         if (m_ref == s) hit = 1'b1;
      end
      if (!hit) begin
         n_err++;
         $error("FAIL timeout_slot: slot %0d not reached, required within %0d cycles", s, 10 * DIV);
      end
   endtask

   task automatic load(input logic [3:0] g);
      carga = 1'b1; gray_in = g;
      step();
      carga = 1'b0; gray_in = 4'd0;
   endtask

   initial begin
      rst = 1'b1; carga = 1'b0; gray_in = 4'd0;
      m_cnt = 0; m_sel = 2'd0; m_pend = 4'd0; m_vis = 4'd0;
      m_ref = 2'd0; m_dig = 4'd0; m_ano = 4'b1111;
      @(negedge clk);

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) step();
      check4("rst_anodo", anodo, 4'b1111);
      check4("rst_digito", digito, 4'b0000);
      check4("rst_ref", {2'b00, refrescamiento}, 4'b0000);

      rst = 1'b0;
      step();
      check4("post_rst_anodo", anodo, 4'b1110);
      check4("post_rst_digito", digito, 4'b0000);

      // Free-running scan, one full frame plus a slot
      for (int i = 0; i < 5 * DIV; i++) step();

      // Load 10
      load(4'b1111);
      go_slot(2'd1); go_slot(2'd3); go_slot(2'd0);
      check4("v10_uni", digito, 4'b0000);
      check4("v10_uni_an", anodo, 4'b1110);
      go_slot(2'd1);
      check4("v10_dec", digito, 4'b0001);
      check4("v10_dec_an", anodo, 4'b1101);

      // Load 15
      load(4'b1000);
      go_slot(2'd1); go_slot(2'd3); go_slot(2'd0);
      check4("v15_uni", digito, 4'b0111);
      go_slot(2'd1);
      check4("v15_dec", digito, 4'b0001);

      // Load 6 exactly in the wrap cycle: 15 stays one more frame
      for (int i = 0; i < 10 * DIV && !(m_cnt == DIV - 1 && m_sel == 2'd3); i++) step();
      load(4'b0101);
      go_slot(2'd0);
      check4("wrap_keep15", digito, 4'b0111);
      go_slot(2'd3); go_slot(2'd0);
      check4("wrap_v6_uni", digito, 4'b0101);
      go_slot(2'd1);
`ifdef BLANK_LEADING_ZERO_EN
      check4("v6_dec_an", anodo, 4'b1111);
      check4("v6_dec", digito, 4'b0000);
`else
      check4("v6_dec_an", anodo, 4'b1101);
      check4("v6_dec", digito, 4'b0000);
`endif

      // Load 12, then reset during slot 2
      load(4'b1010);
      go_slot(2'd1); go_slot(2'd3); go_slot(2'd0);
      check4("v12_uni", digito, 4'b0011);
      go_slot(2'd1);
      check4("v12_dec", digito, 4'b0001);
      go_slot(2'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check4("midrst_anodo", anodo, 4'b1111);
      check4("midrst_digito", digito, 4'b0000);
      check4("midrst_ref", {2'b00, refrescamiento}, 4'b0000);
      step();
      check4("midrst_restart", anodo, 4'b1110);
      go_slot(2'd3); go_slot(2'd0);
      check4("midrst_zero", digito, 4'b0000);
      go_slot(2'd1);
      check4("midrst_zero_dec", digito, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/escaneo_display.md
# escaneo_display

Time-multiplexed driver for the four-digit seven-segment display. It sits upstream of the Gray-digit-to-cathode decoder and produces that decoder's inputs: the digit select `refrescamiento` and the Gray-coded `digito`. It also drives the active-low anodes. A 4-bit Gray-coded value (0–15) is captured and converted to decimal. Units and tens are then scanned out, with updates applied only at frame boundaries so the display never tears.

## Interface
- `DIV`, default 100000: prescaler period in clocks per digit slot; legal range ≥ 2.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `carga` input 1: load strobe; when high, `gray_in` is captured into the pending register.
- `gray_in` input 4: Gray-coded value 0–15.
- `refrescamiento` output 2: current digit slot 0–3, registered.
- `digito` output 4: Gray-coded digit for the current slot, registered.
- `anodo` output 4: one-hot active-low anode enables, registered.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. A `tick` is asserted in the cycle where `cnt == DIV-1`.
- Slot counter `sel` (2 bits) increments on `tick` and wraps 3→0.
- Pending register `pend`:
  - When `carga` is high, `pend <= gray_in`.
  - Otherwise `pend` holds.
- Shown register `vis` loads `pend` only when `tick && sel == 3` (frame wrap). This load uses the `pend` value from before the same edge. A `carga` in the wrap cycle therefore shows one frame later.
- Conversion from `vis`:
  - Gray to binary: `b3 = g3`, `bi = b(i+1) ^ gi`.
  - `dec = b >= 10`.
  - `uni = dec ? b - 10 : b`.
  - `dece = dec ? 1 : 0`.
- Per-slot registered outputs, computed from `sel` and `vis`:
  - slot 0: `anodo = 1110`, `digito = gray(uni)`.
  - slot 1: `anodo = 1101`, `digito = gray(dece)`, i.e. 0000 or 0001.
  - slots 2 and 3: `anodo = 1111`, `digito = 0000`.
- Binary-to-Gray: `g = d ^ (d >> 1)`.
- `refrescamiento` is the registered copy of `sel`.

## Timing
- Reset values: `cnt = 0`, `sel = 0`, `pend = 0`, `vis = 0`, `refrescamiento = 00`, `digito = 0000`, `anodo = 1111`.
- Outputs lag `sel` by one clock. The first cycle after `rst` deasserts shows `anodo = 1110`, `digito = 0000`.
- Each slot lasts exactly DIV clocks. A full frame lasts 4·DIV clocks.
- Latency from `carga` to display:
  - ≥ 1 clock into `pend`.
  - `vis` updates at the next frame wrap.
  - Outputs update one clock after that.
  - Worst case is 4·DIV+1 clocks.
- Back-to-back `carga` pulses: the last one before the wrap edge wins.
- `rst` asserted mid-frame: every register returns to its reset value on that edge. The scan restarts at slot 0.
- Gray input 4'b1000 (=15) is the maximum: tens = 1, units = 5 (Gray 0111).

## Configuration
- `BLANK_LEADING_ZERO_EN`:
  - Defined: when `vis` decodes to < 10, slot 1 drives `anodo = 1111` and `digito = 0000`, so the tens digit is dark.
  - Undefined: slot 1 always lights and shows Gray 0000 ("0") for values < 10.
  - All other behaviour is identical in both builds.

## Structure
- Package `escaneo_pkg` holds:
  - slot constants `SLOT_UNI = 0`, `SLOT_DEC = 1`.
  - anode patterns `ANODO_APAGADO = 4'b1111`, `ANODO_UNI = 4'b1110`, `ANODO_DEC = 4'b1101`.
  - functions `gray_a_bin` and `bin_a_gray` (4-bit).
- Prescaler width is `$clog2(DIV)`, computed locally.
- One sub-module, `gray_a_binario` (combinational 4-bit Gray→binary), instantiated on `vis`. The reverse conversion uses the package function.

## Test plan
- Reset: hold `rst` for 3 cycles → `anodo = 1111`, `digito = 0000`, `refrescamiento = 00`. One cycle after release → `anodo = 1110`.
- DIV=4, no load → slots advance every 4 clocks in the sequence 0,1,2,3,0. `anodo` follows 1110, 1101, 1111, 1111.
- DIV=4, `carga` with `gray_in = 4'b1111` (=10) → after the next wrap, slot 0 `digito = 0000` and slot 1 `digito = 0001`.
- `gray_in = 4'b1000` (=15) loaded → slot 0 `digito = 0111` (5) and slot 1 `digito = 0001`. Loading `4'b0101` (=6) in the wrap cycle → 15 persists one more frame, then slot 0 shows `0101` (6).
- With `BLANK_LEADING_ZERO_EN` and value 6 → slot 1 `anodo = 1111`. Without the macro → slot 1 `anodo = 1101`, `digito = 0000`.
- `rst` pulsed during slot 2 with value 12 shown → next cycle all reset values. The display shows 0 until a new `carga` plus a frame wrap.
